// File: rtl/wb_load_queue.sv
// -----------------------------------------------------------------------------
// wb_load_queue
//
// Load-writeback unit for the memory stage. Outstanding loads are kept in a
// circular buffer in issue order (destination register, funct3, byte offset).
// In-order cache read responses retire the oldest entry: the returned word is
// shifted by the byte offset, sign/zero-extended per funct3 and written back
// to the regfile through a one-cycle output register.
//
// Optional feature: define WB_HAZARD_CHECK_EN to enable the rs1/rs2 busy
// compare against pending destinations. Without it both busy outputs are
// tied low and no compare logic is built (ports stay for a stable interface).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ld_valid/ld_ready     load issue handshake (ld_rd, ld_funct3, ld_addr_lo)
//   i_p_readdata*         cache read response, accepted when waitrequest low
//   i_p_waitrequest       cache stall
//   flush                 drop all pending loads on the next edge
//   reg_we_o/waddr/wdata  registered regfile write port
//   wb_done               one-cycle pulse per retired load (including x0)
//   count_o               number of outstanding loads
//   resp_err_o            sticky: stray response or illegal funct3 retired
//   rs1_i/rs2_i           hazard queries
//   rs1_busy_o/rs2_busy_o query register is the target of a pending load
// -----------------------------------------------------------------------------
module wb_load_queue #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_addr_lo,
    input  logic [DATA_W-1:0]     i_p_readdata,
    input  logic                  i_p_readdata_valid,
    input  logic                  i_p_waitrequest,
    input  logic                  flush,
    output logic                  reg_we_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0]     reg_wdata_o,
    output logic                  wb_done,
    output logic [CNT_W-1:0]      count_o,
    output logic                  resp_err_o,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Returns 1 for funct3 encodings that are not RV32 integer loads.
    function automatic logic funct3_illegal(input logic [2:0] f3);
        logic bad_s;
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_s = 1'b0;
            default:                                 bad_s = 1'b1;
        endcase
        return bad_s;
    endfunction

    // Aligns and extends the low word of the response; bits above 32 stay zero.
    function automatic logic [DATA_W-1:0] extract_load(
        input logic [DATA_W-1:0] data,
        input logic [2:0]        f3,
        input logic [1:0]        off
    );
        logic [31:0] word_s;
        logic [31:0] shifted_s;
        logic [31:0] res_s;
        word_s    = data[31:0];
        shifted_s = word_s >> {off, 3'b000};
        case (f3)
            3'b000:  res_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  res_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b010:  res_s = word_s;
            3'b100:  res_s = {24'h000000, shifted_s[7:0]};
            3'b101:  res_s = {16'h0000, shifted_s[15:0]};
            default: res_s = 32'h00000000;
        endcase
        return DATA_W'(res_s);
    endfunction

    logic [REG_ADDR_W-1:0] ent_rd_r     [DEPTH];
    logic [2:0]            ent_funct3_r [DEPTH];
    logic [1:0]            ent_addr_r   [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  reg_we_r;
    logic [REG_ADDR_W-1:0] reg_waddr_r;
    logic [DATA_W-1:0]     reg_wdata_r;
    logic                  wb_done_r;
    logic                  resp_err_r;

    logic                  accept_s;
    logic                  pop_s;
    logic                  push_s;
    logic [REG_ADDR_W-1:0] pop_rd_s;
    logic [2:0]            pop_funct3_s;
    logic [1:0]            pop_addr_s;

    assign ld_ready     = (count_r != FULL_COUNT);
    assign accept_s     = i_p_readdata_valid & ~i_p_waitrequest;
    assign pop_s        = accept_s & (count_r != {CNT_W{1'b0}});
    // ld_ready looks only at the count so it has no path from the cache
    // response; a load offered while full is still taken when a response
    // frees the head slot in the same cycle.
    assign push_s       = ld_valid & (ld_ready | pop_s) & ~flush;
    assign pop_rd_s     = ent_rd_r[rd_ptr_r];
    assign pop_funct3_s = ent_funct3_r[rd_ptr_r];
    assign pop_addr_s   = ent_addr_r[rd_ptr_r];

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_r[i]     <= {REG_ADDR_W{1'b0}};
                ent_funct3_r[i] <= 3'b000;
                ent_addr_r[i]   <= 2'b00;
            end
            valid_r  <= {DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            valid_r  <= {DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            // Pop clears first so a push into the same slot (full, both
            // happening) leaves the slot valid.
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s) begin
                ent_rd_r[wr_ptr_r]     <= ld_rd;
                ent_funct3_r[wr_ptr_r] <= ld_funct3;
                ent_addr_r[wr_ptr_r]   <= ld_addr_lo;
                valid_r[wr_ptr_r]      <= 1'b1;
                wr_ptr_r               <= wr_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Registered writeback; a pop coinciding with flush still retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we_r    <= 1'b0;
            reg_waddr_r <= {REG_ADDR_W{1'b0}};
            reg_wdata_r <= {DATA_W{1'b0}};
            wb_done_r   <= 1'b0;
        end else if (pop_s) begin
            reg_we_r    <= (pop_rd_s != {REG_ADDR_W{1'b0}});
            reg_waddr_r <= pop_rd_s;
            reg_wdata_r <= extract_load(i_p_readdata, pop_funct3_s, pop_addr_s);
            wb_done_r   <= 1'b1;
        end else begin
            reg_we_r    <= 1'b0;
            reg_waddr_r <= {REG_ADDR_W{1'b0}};
            reg_wdata_r <= {DATA_W{1'b0}};
            wb_done_r   <= 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_r <= 1'b0;
        end else if ((accept_s & ~pop_s) | (pop_s & funct3_illegal(pop_funct3_s))) begin
            resp_err_r <= 1'b1;
        end else begin
            resp_err_r <= resp_err_r;
        end
    end

    assign reg_we_o    = reg_we_r;
    assign reg_waddr_o = reg_waddr_r;
    assign reg_wdata_o = reg_wdata_r;
    assign wb_done     = wb_done_r;
    assign count_o     = count_r;
    assign resp_err_o  = resp_err_r;

`ifdef WB_HAZARD_CHECK_EN
    logic rs1_hit_s;
    logic rs2_hit_s;

    // Match queries against every valid entry, including the one being popped.
    always_comb begin
        rs1_hit_s = 1'b0;
        rs2_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rs1_hit_s = rs1_hit_s | (valid_r[i] & (ent_rd_r[i] == rs1_i));
            rs2_hit_s = rs2_hit_s | (valid_r[i] & (ent_rd_r[i] == rs2_i));
        end
    end

    assign rs1_busy_o = rs1_hit_s & (rs1_i != {REG_ADDR_W{1'b0}});
    assign rs2_busy_o = rs2_hit_s & (rs2_i != {REG_ADDR_W{1'b0}});
`else
    logic unused_hazard_s;

    assign unused_hazard_s = ^{rs1_i, rs2_i, valid_r};
    assign rs1_busy_o      = 1'b0;
    assign rs2_busy_o      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_load_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_load_queue
//
// Table of single-load extension vectors plus hand-written sequences (full
// queue ordering, waitrequest, flush, hazard, stray response, async reset).
// A model queue of pending loads produces expected writebacks, which are
// pushed to a scoreboard when a response is driven and compared one cycle
// later when the DUT retires.
// -----------------------------------------------------------------------------
module tb_wb_load_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] rdata;
    logic        rvalid;
    logic        waitreq;
    logic        flush;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        wb_done;
    logic [2:0]  count_o;
    logic        resp_err_o;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy_o;
    logic        rs2_busy_o;

    wb_load_queue dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ld_valid           (ld_valid),
        .ld_ready           (ld_ready),
        .ld_rd              (ld_rd),
        .ld_funct3          (ld_funct3),
        .ld_addr_lo         (ld_addr_lo),
        .i_p_readdata       (rdata),
        .i_p_readdata_valid (rvalid),
        .i_p_waitrequest    (waitreq),
        .flush              (flush),
        .reg_we_o           (reg_we_o),
        .reg_waddr_o        (reg_waddr_o),
        .reg_wdata_o        (reg_wdata_o),
        .wb_done            (wb_done),
        .count_o            (count_o),
        .resp_err_o         (resp_err_o),
        .rs1_i              (rs1),
        .rs2_i              (rs2),
        .rs1_busy_o         (rs1_busy_o),
        .rs2_busy_o         (rs2_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    typedef struct {
        logic       we;
        logic [4:0] waddr;
        logic [31:0] wdata;
        logic       chk_data;
    } wb_t;

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] data;
        logic        we;
        logic [31:0] exp;
    } vec_t;

    ld_t  mq[$];
    wb_t  exp_q[$];
    logic m_err;
    int   checks = 0;
    int   errors = 0;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [63:0] d64;
        logic [7:0]  b;
        logic [15:0] h;
        int          base;
        d64  = {32'h0, d};
        base = 8 * int'(off);
        b    = d64[base +: 8];
        h    = d64[base +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            3'b010:  return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [2:0] f3);
        return !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction

    function automatic logic ref_busy(input logic [4:0] r);
`ifdef WB_HAZARD_CHECK_EN
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) begin
            if (mq[i].rd == r) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    // One clock cycle: drive, update model, advance, compare.
    task automatic step(input logic lv, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] off, input logic rv, input logic wr,
                        input logic [31:0] data, input logic fl);
        logic acc;
        logic pop;
        logic push;
        ld_t  e;
        wb_t  w;
        ld_valid   = lv;
        ld_rd      = rd;
        ld_funct3  = f3;
        ld_addr_lo = off;
        rvalid     = rv;
        waitreq    = wr;
        rdata      = data;
        flush      = fl;
        #1;
        // Pre-edge view: an entry being popped this cycle is still busy.
        chk("rs1_busy_pre", 32'(rs1_busy_o), 32'(ref_busy(rs1)));
        chk("rs2_busy_pre", 32'(rs2_busy_o), 32'(ref_busy(rs2)));
        acc  = rv && !wr;
        pop  = acc && (mq.size() > 0);
        push = lv && ((mq.size() < DEPTH) || pop) && !fl;
        if (acc && !pop) m_err = 1'b1;
        if (pop) begin
            e          = mq.pop_front();
            w.we       = (e.rd != 5'd0);
            w.waddr    = e.rd;
            w.wdata    = ref_ext(e.f3, e.off, data);
            w.chk_data = (e.rd != 5'd0);
            exp_q.push_back(w);
            if (ref_illegal(e.f3)) m_err = 1'b1;
        end
        if (fl) begin
            mq.delete();
        end else if (push) begin
            e.rd  = rd;
            e.f3  = f3;
            e.off = off;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("ld_ready", 32'(ld_ready), 32'(mq.size() != DEPTH));
        chk("resp_err", 32'(resp_err_o), 32'(m_err));
        chk("rs1_busy", 32'(rs1_busy_o), 32'(ref_busy(rs1)));
        chk("rs2_busy", 32'(rs2_busy_o), 32'(ref_busy(rs2)));
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("wb_done", 32'(wb_done), 32'd1);
            chk("reg_we", 32'(reg_we_o), 32'(w.we));
            chk("reg_waddr", 32'(reg_waddr_o), 32'(w.waddr));
            if (w.chk_data) chk("reg_wdata", reg_wdata_o, w.wdata);
        end else begin
            chk("wb_done_idle", 32'(wb_done), 32'd0);
            chk("reg_we_idle", 32'(reg_we_o), 32'd0);
            chk("reg_waddr_idle", 32'(reg_waddr_o), 32'd0);
            chk("reg_wdata_idle", reg_wdata_o, 32'd0);
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 3'b000, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic push(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        step(1'b1, rd, f3, off, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic resp(input logic [31:0] data);
        step(1'b0, 5'd0, 3'b000, 2'd0, 1'b1, 1'b0, data, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"}, 32'(count_o), 32'd0);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
        chk({tag, "_reg_we"}, 32'(reg_we_o), 32'd0);
        chk({tag, "_waddr"}, 32'(reg_waddr_o), 32'd0);
        chk({tag, "_wdata"}, reg_wdata_o, 32'd0);
        chk({tag, "_wb_done"}, 32'(wb_done), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{5'd5,  3'b010, 2'd0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vecs[1] = '{5'd8,  3'b000, 2'd3, 32'h80123456, 1'b1, 32'hFFFFFF80};
        vecs[2] = '{5'd9,  3'b100, 2'd3, 32'h80123456, 1'b1, 32'h00000080};
        vecs[3] = '{5'd10, 3'b001, 2'd2, 32'h7FFF0000, 1'b1, 32'h00007FFF};
        vecs[4] = '{5'd11, 3'b001, 2'd0, 32'h12348765, 1'b1, 32'hFFFF8765};
        vecs[5] = '{5'd12, 3'b101, 2'd0, 32'h12348765, 1'b1, 32'h00008765};
        vecs[6] = '{5'd13, 3'b000, 2'd1, 32'h000055AA, 1'b1, 32'h00000055};
        vecs[7] = '{5'd14, 3'b010, 2'd2, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        vecs[8] = '{5'd31, 3'b100, 2'd2, 32'h00AB0000, 1'b1, 32'h000000AB};
        vecs[9] = '{5'd0,  3'b010, 2'd0, 32'h12345678, 1'b0, 32'h00000000};

        rst_n = 1'b0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_funct3 = 3'b000; ld_addr_lo = 2'd0;
        rdata = 32'h0; rvalid = 1'b0; waitreq = 1'b0; flush = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Single-load vectors: push, respond, then compare against table.
        for (int i = 0; i < NV; i++) begin
            push(vecs[i].rd, vecs[i].f3, vecs[i].off);
            resp(vecs[i].data);
            chk($sformatf("vec%0d_we", i), 32'(reg_we_o), 32'(vecs[i].we));
            chk($sformatf("vec%0d_waddr", i), 32'(reg_waddr_o), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_done", i), 32'(wb_done), 32'd1);
            if (vecs[i].we) chk($sformatf("vec%0d_wdata", i), reg_wdata_o, vecs[i].exp);
        end

        // Fill, drop a push while full, push-with-pop at full, drain in order.
        for (int r = 1; r <= 4; r++) push(5'(r), 3'b010, 2'd0);
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        push(5'd9, 3'b010, 2'd0);
        step(1'b1, 5'd6, 3'b010, 2'd0, 1'b1, 1'b0, 32'h00000101, 1'b0);
        chk("full_swap_count", 32'(count_o), 32'd4);
        resp(32'h00000102);
        chk("order_2", 32'(reg_waddr_o), 32'd2);
        resp(32'h00000103);
        chk("order_3", 32'(reg_waddr_o), 32'd3);
        resp(32'h00000104);
        chk("order_4", 32'(reg_waddr_o), 32'd4);
        resp(32'h00000106);
        chk("order_6", 32'(reg_waddr_o), 32'd6);
        idle();

        // Waitrequest holds the response off for two cycles.
        push(5'd11, 3'b010, 2'd0);
        step(1'b0, 5'd0, 3'b000, 2'd0, 1'b1, 1'b1, 32'h11111111, 1'b0);
        step(1'b0, 5'd0, 3'b000, 2'd0, 1'b1, 1'b1, 32'h11111111, 1'b0);
        chk("wait_count", 32'(count_o), 32'd1);
        resp(32'h22222222);
        idle();

        // Hazard query, then flush with a pop and a discarded push together.
        rs1 = 5'd7; rs2 = 5'd0;
        push(5'd7, 3'b010, 2'd0);
        push(5'd0, 3'b010, 2'd0);
        rs2 = 5'd7;
        idle();
        rs2 = 5'd0;
        idle();
        step(1'b1, 5'd12, 3'b010, 2'd0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1);
        chk("flush_waddr", 32'(reg_waddr_o), 32'd7);
        chk("flush_count", 32'(count_o), 32'd0);
        rs1 = 5'd12;
        idle();
        chk("flush_rs1_busy", 32'(rs1_busy_o), 32'd0);
        rs1 = 5'd0;

        // Illegal funct3 writes zero and sets the sticky error.
        push(5'd9, 3'b011, 2'd0);
        resp(32'hFFFFFFFF);
        chk("illegal_wdata", reg_wdata_o, 32'd0);
        chk("illegal_err", 32'(resp_err_o), 32'd1);

        // Asynchronous reset with three loads pending.
        push(5'd1, 3'b010, 2'd0);
        push(5'd2, 3'b010, 2'd0);
        push(5'd3, 3'b010, 2'd0);
        ld_valid = 1'b0; rvalid = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        mq.delete();
        exp_q.delete();
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Stray response with empty queue; flush must not clear the error.
        resp(32'h00000005);
        chk("stray_err", 32'(resp_err_o), 32'd1);
        chk("stray_we", 32'(reg_we_o), 32'd0);
        step(1'b0, 5'd0, 3'b000, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("err_after_flush", 32'(resp_err_o), 32'd1);
        idle();

        chk("pending_wb", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
